// File: rtl/i2c_led_regfile.sv
// i2c_led_regfile: register bank between an I2C slave register handshake and a
// WS2812B serial driver. It holds the on-board RGB LED bits and a pixel RAM of
// 24-bit GRB words, serves pixel words to the driver, and sequences frame refreshes.
// Optional feature macro: SHADOW_BUFFER_EN. When it is defined, the RAM is double
// buffered: I2C writes go to the back bank, and the banks swap on frame start.
module i2c_led_regfile #(
  parameter int          NUM_PIXELS = 8,
  parameter logic [7:0]  ID_VALUE   = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  reg_address,
  input  logic        reg_is_write,
  input  logic        reg_request,
  input  logic [7:0]  reg_write_data,
  output logic        reg_response,
  output logic [7:0]  reg_read_data,
  output logic [2:0]  led_out,
  input  logic        pixel_req,
  input  logic [5:0]  pixel_index,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [6:0]  pixel_count,
  output logic        frame_start,
  input  logic        frame_busy
);

  localparam logic [6:0] NP7 = 7'(NUM_PIXELS);
  localparam logic [7:0] NP8 = 8'(NUM_PIXELS);
`ifdef SHADOW_BUFFER_EN
  localparam int AW = 7;   // {bank, pixel}
`else
  localparam int AW = 6;
`endif
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t      r_state, w_state_next;
  logic        r_response, r_pixel_valid, r_pending, r_auto;
  logic [7:0]  r_read_data;
  logic [2:0]  r_led;
  logic [6:0]  r_count;
  logic [5:0]  r_ptr;
  logic [1:0]  r_byte_cnt;

  logic        w_mapped, w_rd, w_wr, w_data_acc, w_refresh_wr, w_frame_start;
  logic [6:0]  w_count_val;
  logic [5:0]  w_ptr_wr_val, w_ptr_inc;
  logic [7:0]  w_data_byte;
  logic [2:0][7:0] w_lane_rd, w_pix_lane;
  logic [AW-1:0]   w_back_addr, w_front_addr;

  // Address decode, COUNT clamping and pointer arithmetic.
  always_comb begin
    w_mapped     = (reg_address <= 7'h04) || (reg_address == 7'h08) || (reg_address == 7'h09);
    w_rd         = reg_request && !reg_is_write;
    w_wr         = reg_request && reg_is_write;
    w_data_acc   = reg_request && (reg_address == 7'h09);
    w_refresh_wr = w_wr && (reg_address == 7'h03) && reg_write_data[0];
    if (reg_write_data == 8'd0)     w_count_val = 7'd1;
    else if (reg_write_data > NP8)  w_count_val = NP7;
    else                            w_count_val = reg_write_data[6:0];
    w_ptr_wr_val = ({1'b0, reg_write_data[5:0]} >= r_count) ? 6'd0 : reg_write_data[5:0];
    w_ptr_inc    = ({1'b0, r_ptr} >= (r_count - 7'd1)) ? 6'd0 : r_ptr + 6'd1;
    case (r_byte_cnt)
      2'd0:    w_data_byte = w_lane_rd[0];
      2'd1:    w_data_byte = w_lane_rd[1];
      default: w_data_byte = w_lane_rd[2];
    endcase
  end

`ifdef SHADOW_BUFFER_EN
  logic r_front;
  assign w_back_addr  = {~r_front, r_ptr};
  assign w_front_addr = {r_front, pixel_index};

  // Swap banks as the FSM enters START so the driver sees a whole frame at once.
  always_ff @(posedge clock) begin
    if (reset)                                         r_front <= 1'b0;
    else if (r_state == S_IDLE && w_state_next == S_START) r_front <= ~r_front;
  end
`else
  assign w_back_addr  = r_ptr;
  assign w_front_addr = pixel_index;
`endif

  // One RAM per byte lane (G, R, B) so each DATA write touches a single byte.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] r_mem [0:DEPTH-1];
      logic [7:0] r_pix_q;

      // Byte write from the I2C DATA register.
      always_ff @(posedge clock) begin
        if (w_data_acc && reg_is_write && r_byte_cnt == 2'(gi))
          r_mem[w_back_addr] <= reg_write_data;
      end

      // Registered driver read; read-before-write on a same-address collision.
      always_ff @(posedge clock) begin
        if (reset)          r_pix_q <= 8'd0;
        else if (pixel_req) r_pix_q <= r_mem[w_front_addr];
      end

      assign w_lane_rd[gi]  = r_mem[w_back_addr];
      assign w_pix_lane[gi] = r_pix_q;
    end
  endgenerate

  // Register file: handshake, read mux and writable fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_response  <= 1'b0;
      r_read_data <= 8'd0;
      r_led       <= 3'd0;
      r_count     <= NP7;
      r_auto      <= 1'b0;
      r_ptr       <= 6'd0;
      r_byte_cnt  <= 2'd0;
    end else begin
      r_response  <= reg_request && w_mapped;
      r_read_data <= 8'd0;
      if (w_rd) begin
        case (reg_address)
          7'h00:   r_read_data <= ID_VALUE;
          7'h01:   r_read_data <= {5'd0, r_led};
          7'h02:   r_read_data <= {1'b0, r_count};
          7'h03:   r_read_data <= {6'd0, r_auto, r_pending};
          7'h04:   r_read_data <= {6'd0, r_pending, frame_busy};
          7'h08:   r_read_data <= {2'd0, r_ptr};
          7'h09:   r_read_data <= w_data_byte;
          default: r_read_data <= 8'd0;
        endcase
      end
      if (w_wr) begin
        case (reg_address)
          7'h01: r_led <= reg_write_data[2:0];
          7'h02: begin
            r_count <= w_count_val;
            // Keep the pointer inside the shrunken pixel range.
            if ({1'b0, r_ptr} >= w_count_val) r_ptr <= 6'd0;
          end
          7'h03: r_auto <= reg_write_data[1];
          7'h08: begin
            r_ptr      <= w_ptr_wr_val;
            r_byte_cnt <= 2'd0;
          end
          default: ;
        endcase
      end
      if (w_data_acc) begin
        if (r_byte_cnt == 2'd2) begin
          r_byte_cnt <= 2'd0;
          r_ptr      <= w_ptr_inc;
        end else begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end
    end
  end

  // Pixel port valid strobe, one cycle behind the request.
  always_ff @(posedge clock) begin
    if (reset) r_pixel_valid <= 1'b0;
    else       r_pixel_valid <= pixel_req;
  end

  // Pending refresh: a new request always wins over the clear in START.
  always_ff @(posedge clock) begin
    if (reset)
      r_pending <= 1'b0;
    else if (w_refresh_wr || (r_state == S_WAIT_DONE && !frame_busy && r_auto))
      r_pending <= 1'b1;
    else if (r_state == S_START)
      r_pending <= 1'b0;
  end

  // Refresh FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Refresh FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (r_pending && !frame_busy) w_state_next = S_START;
      S_START:     w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (frame_busy)  w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!frame_busy) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Refresh FSM outputs.
  always_comb begin
    w_frame_start = (r_state == S_START);
  end

  assign reg_response  = r_response;
  assign reg_read_data = r_read_data;
  assign led_out       = r_led;
  assign pixel_count   = r_count;
  assign pixel_valid   = r_pixel_valid;
  assign pixel_data    = {w_pix_lane[0], w_pix_lane[1], w_pix_lane[2]};
  assign frame_start   = w_frame_start;

endmodule

// File: tb/tb_i2c_led_regfile.sv
// Directed bench for i2c_led_regfile: register map, pixel RAM access,
// refresh sequencing against a simple busy model, and reset mid-frame.
module tb_i2c_led_regfile;

  logic        clk = 1'b0;
  logic        srst;
  logic [6:0]  reg_address;
  logic        reg_is_write, reg_request;
  logic [7:0]  reg_write_data;
  logic        reg_response;
  logic [7:0]  reg_read_data;
  logic [2:0]  led_out;
  logic        pixel_req;
  logic [5:0]  pixel_index;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [6:0]  pixel_count;
  logic        frame_start;
  logic        frame_busy;

  int n_total = 0;
  int n_bad   = 0;
  int n_starts = 0;

  i2c_led_regfile #(.NUM_PIXELS(8), .ID_VALUE(8'hA5)) dut (
    .clock(clk), .reset(srst),
    .reg_address(reg_address), .reg_is_write(reg_is_write), .reg_request(reg_request),
    .reg_write_data(reg_write_data), .reg_response(reg_response), .reg_read_data(reg_read_data),
    .led_out(led_out), .pixel_req(pixel_req), .pixel_index(pixel_index),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_count(pixel_count),
    .frame_start(frame_start), .frame_busy(frame_busy)
  );

  always #5 clk = ~clk;

  // Count frame_start cycles away from the active edge.
  always @(negedge clk) if (frame_start) n_starts++;

  // Driver busy model: busy rises 2 cycles after frame_start and lasts 10 cycles.
  initial begin
    frame_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_start) begin
        repeat (2) @(negedge clk);
        frame_busy = 1'b1;
        repeat (10) @(negedge clk);
        frame_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reg_xfer(input logic wr, input logic [6:0] addr, input logic [7:0] wd,
                          output logic rsp, output logic [7:0] rd);
    @(negedge clk);
    reg_request = 1'b1; reg_is_write = wr; reg_address = addr; reg_write_data = wd;
    @(negedge clk);
    reg_request = 1'b0;
    rsp = reg_response; rd = reg_read_data;
    $display("txn %s a=%02h wd=%02h rsp=%0d rd=%02h", wr ? "wr" : "rd", addr, wd, rsp, rd);
  endtask

  task automatic reg_wr(input string tag, input logic [6:0] addr, input logic [7:0] wd);
    logic rsp; logic [7:0] rd;
    reg_xfer(1'b1, addr, wd, rsp, rd);
    chk(tag, {31'd0, rsp}, 32'd1);
  endtask

  task automatic reg_rd_chk(input string tag, input logic [6:0] addr, input logic [7:0] exp);
    logic rsp; logic [7:0] rd;
    reg_xfer(1'b0, addr, 8'h00, rsp, rd);
    chk(tag, {23'd0, rsp, rd}, {23'd0, 1'b1, exp});
  endtask

  task automatic pix_rd_chk(input string tag, input logic [5:0] idx, input logic [23:0] exp);
    @(negedge clk);
    pixel_req = 1'b1; pixel_index = idx;
    @(negedge clk);
    pixel_req = 1'b0;
    $display("txn pix idx=%0d valid=%0d data=%06h", idx, pixel_valid, pixel_data);
    chk(tag, {7'd0, pixel_valid, pixel_data}, {7'd0, 1'b1, exp});
  endtask

  task automatic wait_busy(input string tag);
    int k;
    k = 0;
    while (!frame_busy && k < 50) begin @(negedge clk); k++; end
    chk(tag, {31'd0, frame_busy}, 32'd1);
  endtask

  initial begin : main
    logic rsp; logic [7:0] rd;
    int snap;
    srst = 1'b1; reg_request = 1'b0; reg_is_write = 1'b0; reg_address = 7'd0;
    reg_write_data = 8'd0; pixel_req = 1'b0; pixel_index = 6'd0;
    repeat (3) @(negedge clk);
    srst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_outs", {reg_response, reg_read_data, led_out, pixel_valid, frame_start},
        32'd0);
    chk("rst_pixdata", {8'd0, pixel_data}, 32'd0);
    chk("rst_count", {25'd0, pixel_count}, 32'd8);

    // ID and unmapped address
    reg_rd_chk("id", 7'h00, 8'hA5);
    reg_xfer(1'b0, 7'h05, 8'h00, rsp, rd);
    chk("unmapped_rsp", {31'd0, rsp}, 32'd0);

    // LED
    reg_wr("led_wr", 7'h01, 8'hFF);
    chk("led_out", {29'd0, led_out}, 32'd7);
    reg_rd_chk("led_rd", 7'h01, 8'h07);

    // COUNT clamping
    reg_wr("cnt_wr0", 7'h02, 8'd0);
    reg_rd_chk("cnt_min", 7'h02, 8'd1);
    reg_wr("cnt_wr200", 7'h02, 8'd200);
    reg_rd_chk("cnt_max", 7'h02, 8'd8);
    chk("pixel_count", {25'd0, pixel_count}, 32'd8);

    // DATA stream writes: pixel 0 = 112233, pixel 1 = 445566
    reg_wr("ptr_wr", 7'h08, 8'd0);
    reg_wr("d0", 7'h09, 8'h11); reg_wr("d1", 7'h09, 8'h22); reg_wr("d2", 7'h09, 8'h33);
    reg_wr("d3", 7'h09, 8'h44); reg_wr("d4", 7'h09, 8'h55); reg_wr("d5", 7'h09, 8'h66);
    reg_rd_chk("ptr_after6", 7'h08, 8'd2);

    // DATA reads also advance the byte counter and pointer
    reg_wr("ptr_wr1", 7'h08, 8'd1);
    reg_rd_chk("rd_g", 7'h09, 8'h44);
    reg_rd_chk("rd_r", 7'h09, 8'h55);
    reg_rd_chk("rd_b", 7'h09, 8'h66);
    reg_rd_chk("ptr_after_rd", 7'h08, 8'd2);

    // Shrinking COUNT wraps the pointer; oversized PTR writes wrap to 0
    reg_wr("cnt2", 7'h02, 8'd2);
    reg_rd_chk("ptr_wrap_cnt", 7'h08, 8'd0);
    reg_wr("cnt8", 7'h02, 8'd8);
    reg_wr("ptr9", 7'h08, 8'd9);
    reg_rd_chk("ptr_wrap_wr", 7'h08, 8'd0);
    reg_wr("ptr7", 7'h08, 8'd7);
    reg_wr("d7g", 7'h09, 8'h77); reg_wr("d7r", 7'h09, 8'h88); reg_wr("d7b", 7'h09, 8'h99);
    reg_rd_chk("ptr_wrap_end", 7'h08, 8'd0);

`ifndef SHADOW_BUFFER_EN
    // Pixel port: 1-cycle latency, single cycle valid
    pix_rd_chk("pix0", 6'd0, 24'h112233);
    @(negedge clk);
    chk("pix_valid_drop", {31'd0, pixel_valid}, 32'd0);
    pix_rd_chk("pix1", 6'd1, 24'h445566);
    pix_rd_chk("pix7", 6'd7, 24'h778899);

    // Same-cycle write and read of pixel 0 returns the old word
    reg_wr("ptr0b", 7'h08, 8'd0);
    @(negedge clk);
    reg_request = 1'b1; reg_is_write = 1'b1; reg_address = 7'h09; reg_write_data = 8'hAA;
    pixel_req = 1'b1; pixel_index = 6'd0;
    @(negedge clk);
    reg_request = 1'b0; pixel_req = 1'b0;
    $display("txn wr+pix a=09 wd=aa data=%06h", pixel_data);
    chk("rbw_old", {8'd0, pixel_data}, 32'h112233);
    pix_rd_chk("rbw_new", 6'd0, 24'hAA2233);
`else
    // Back-bank writes stay hidden until the refresh swaps banks
    reg_wr("sh_ptr0", 7'h08, 8'd0);
    reg_wr("sh_a0", 7'h09, 8'h01); reg_wr("sh_a1", 7'h09, 8'h02); reg_wr("sh_a2", 7'h09, 8'h03);
    reg_wr("sh_ref1", 7'h03, 8'h01);
    repeat (30) @(negedge clk);
    pix_rd_chk("sh_v1", 6'd0, 24'h010203);
    reg_wr("sh_ptr0b", 7'h08, 8'd0);
    reg_wr("sh_b0", 7'h09, 8'h0A); reg_wr("sh_b1", 7'h09, 8'h0B); reg_wr("sh_b2", 7'h09, 8'h0C);
    pix_rd_chk("sh_hidden", 6'd0, 24'h010203);
    reg_wr("sh_ref2", 7'h03, 8'h01);
    repeat (30) @(negedge clk);
    pix_rd_chk("sh_v2", 6'd0, 24'h0A0B0C);
`endif

    // Single refresh: exactly one frame_start, pending cleared
    snap = n_starts;
    reg_wr("ctl_ref", 7'h03, 8'h01);
    wait_busy("busy1");
    reg_rd_chk("status_busy", 7'h04, 8'h01);
    repeat (30) @(negedge clk);
    chk("one_start", n_starts - snap, 1);
    reg_rd_chk("status_idle", 7'h04, 8'h00);

    // Refresh request during a frame is kept and starts the next frame
    snap = n_starts;
    reg_wr("ctl_ref2", 7'h03, 8'h01);
    wait_busy("busy2");
    reg_wr("ctl_ref_mid", 7'h03, 8'h01);
    reg_rd_chk("status_pend", 7'h04, 8'h03);
    repeat (60) @(negedge clk);
    chk("two_starts", n_starts - snap, 2);

    // AUTO re-arms after each completed frame
    snap = n_starts;
    reg_wr("ctl_auto", 7'h03, 8'h03);
    repeat (80) @(negedge clk);
    chk("auto_repeat", {31'd0, (n_starts - snap) >= 4}, 32'd1);
    reg_wr("ctl_off", 7'h03, 8'h00);
    repeat (40) @(negedge clk);
    snap = n_starts;
    repeat (40) @(negedge clk);
    chk("auto_stopped", n_starts - snap, 0);

    // Reset while waiting for the frame to finish: no further frame_start
    reg_wr("ctl_auto2", 7'h03, 8'h03);
    wait_busy("busy3");
    repeat (2) @(negedge clk);
    snap = n_starts;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_no_start", n_starts - snap, 0);
    reg_rd_chk("rst_status", 7'h04, 8'h00);
    reg_rd_chk("rst_ctl", 7'h03, 8'h00);
    chk("rst_count2", {25'd0, pixel_count}, 32'd8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
